data_memory_mux: RTL and testbench
==================================

// Module: data_memory_mux
// PURPOSE
//  MEM-stage data-memory block of the 5-stage MIPS pipeline: word-organised data RAM plus
//  the MEM->MEM forwarding 2:1 mux that selects the store data. The ALU result is the byte
//  address. Loads read combinationally. Stores commit on the clock edge. Sits between the
//  EX/MEM and MEM/WB registers.
// PARAMETERS
//  DATA_W     32           word width in bits
//  DEPTH      1024         number of words; power of two
//  BASE_ADDR  32'h00000000 byte address of word 0; must be DEPTH*4-aligned
// PORTS
//  clk            in   1       clock; stores commit on the rising edge
//  reset          in   1       asynchronous, active-high; clears the whole array
//  mem_write      in   1       MemWriteM: store enable
//  forward_mm     in   1       ForwardMM: 1 = store data from WB result
//  alu_out_m      in   32      ALUOutM: byte address
//  write_data_m   in   DATA_W  WriteDataM: store data from the EX/MEM register
//  result_w       in   DATA_W  ResultW: WB-stage result, used for forwarding
//  rd             out  DATA_W  load data (RD)
//  store_data     out  DATA_W  store data after the forwarding mux (debug/visibility)
// BEHAVIOUR
//  Interface rule: one clock; reset is asynchronous and active-high.
//  - Forward mux: store_data = forward_mm ? result_w : write_data_m. Purely combinational.
//  - Address decode:
//    - off = alu_out_m - BASE_ADDR.
//    - in_range = (alu_out_m >= BASE_ADDR) && (off < DEPTH*4).
//    - idx = off[$clog2(DEPTH)+1:2].
//    - off[1:0] is ignored: word accesses only; misaligned addresses act as aligned.
//  - Read:
//    - rd = in_range ? mem[idx] : 0. Combinational, zero latency.
//    - Valid whenever the address is stable, regardless of mem_write.
//  - Write:
//    - Occurs on posedge clk when mem_write && in_range && !reset: mem[idx] <= store_data.
//    - Out-of-range writes are dropped silently and leave the array unchanged.
//  - Read-during-write, same word: rd shows the OLD word until the edge, then the new word
//    in the same cycle after the edge. No write-first bypass.
//  - Reset:
//    - Asserting reset immediately clears every word to 0, without waiting for a clock.
//    - rd therefore reads 0 during reset and after it.
//    - A write coincident with the reset edge, or while reset is held, is lost.
//  - After the power-on reset, all words read 0. No X ever appears on rd.
//  - mem_write with forward_mm=1 stores result_w, not write_data_m.
//  - Full 32-bit arithmetic on off (wraps mod 2^32); in_range guards the wrap.
// STRUCTURE
//  - Shared pipeline package: DATA_W, the word-size constant (4) and the BASE_ADDR default.
//  - One natural sub-module: mux, a 2:1 parameterised-width mux with ports (sel, a, b, y),
//    y = sel ? b : a. Instantiate it as the forwarding mux.
//  - Everything else is the array, the decode and the write process in data_memory_mux.
// TESTING
//  1 Reset then read: pulse reset; read 0x0, 0x4, 0xFFC -> rd = 0 each.
//  2 Store/load:
//    - mem_write=1, forward_mm=0, addr=0x8, write_data_m=0xDEADBEEF, one edge.
//    - mem_write=0 -> rd=0xDEADBEEF; addr 0xA also -> 0xDEADBEEF.
//    - addr 0xC -> 0.
//  3 Forwarding:
//    - forward_mm=1, result_w=0x12345678, write_data_m=0xFFFFFFFF, addr=0x10, write.
//    - Then rd@0x10 = 0x12345678, and store_data followed result_w before the edge.
//  4 Read-during-write:
//    - mem[0x20]=0x1. Write 0x2 to 0x20.
//    - rd=0x1 before the edge, 0x2 after it.
//  5 Out of range (DEPTH=1024):
//    - Write 0xAAAA5555 to 0x1000 -> dropped; rd@0x1000 = 0; rd@0x0 unchanged.
//    - BASE_ADDR=0x10010000: addr 0x1000FFFC -> rd=0.
//  6 Async reset mid-operation:
//    - Fill 0x0/0x4 with nonzero data. Assert reset between edges -> rd drops to 0 at once.
//    - A write held during reset is not committed.

Source files
------------

// File: rtl/data_memory_mux_pkg.sv
// Shared MEM-stage constants for the 5-stage pipeline data-memory block.
//   PIPE_DATA_W     : default datapath word width in bits
//   WORD_BYTES      : bytes per word (word-addressed RAM, byte-addressed bus)
//   PIPE_BASE_ADDR  : default byte address of data-memory word 0
package data_memory_mux_pkg;

    localparam int unsigned PIPE_DATA_W    = 32;
    localparam int unsigned WORD_BYTES     = 4;
    localparam logic [31:0] PIPE_BASE_ADDR = 32'h0000_0000;

endpackage : data_memory_mux_pkg

// File: rtl/mux.sv
// Parameterised-width 2:1 multiplexer, y = sel ? b : a.
//   sel : select (1 picks b)
//   a   : input taken when sel = 0
//   b   : input taken when sel = 1
//   y   : selected value (combinational)
module mux #(
    parameter int unsigned W = 32
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = sel ? b : a;

endmodule : mux

// File: rtl/data_memory_mux.sv
// MEM-stage data memory: word-organised RAM with combinational loads, clocked
// stores, and the MEM->MEM forwarding mux that selects the store data.
//   clk          : clock, stores commit on the rising edge
//   reset        : asynchronous active-high, clears the whole array
//   mem_write    : store enable
//   forward_mm   : 1 = store data comes from the WB-stage result
//   alu_out_m    : byte address
//   write_data_m : store data from the EX/MEM register
//   result_w     : WB-stage result used for forwarding
//   rd           : load data, zero when the address is out of range
//   store_data   : store data after the forwarding mux
module data_memory_mux
    import data_memory_mux_pkg::*;
#(
    parameter int unsigned DATA_W    = PIPE_DATA_W,
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = PIPE_BASE_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_write,
    input  logic              forward_mm,
    input  logic [31:0]       alu_out_m,
    input  logic [DATA_W-1:0] write_data_m,
    input  logic [DATA_W-1:0] result_w,
    output logic [DATA_W-1:0] rd,
    output logic [DATA_W-1:0] store_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    // Byte span of the array; 33 bits so a 4 GiB span cannot overflow.
    localparam logic [32:0] SPAN = 33'(DEPTH) * 33'(WORD_BYTES);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [31:0]       off;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic              wr_en;

    // Forwarding mux: WB result overrides the EX/MEM store data.
    mux #(
        .W   (DATA_W)
    ) u_fwd_mux (
        .sel (forward_mm),
        .a   (write_data_m),
        .b   (result_w),
        .y   (store_data)
    );

    // Address decode; off wraps mod 2^32 and the lower-bound test guards the wrap.
    always_comb begin
        off      = alu_out_m - BASE_ADDR;
        in_range = (alu_out_m >= BASE_ADDR) && ({1'b0, off} < SPAN);
        idx      = off[IDX_W+1:2];
        wr_en    = mem_write && in_range;
    end

    // Combinational load, forced to zero outside the window.
    assign rd = in_range ? mem_q[idx] : '0;

    // Array storage: reset clears everything and wins over a coincident store.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[idx] <= store_data;
        end
    end

endmodule : data_memory_mux

// File: tb/tb_data_memory_mux.sv
// Randomised, model-checked bench for data_memory_mux.
module tb_data_memory_mux;

    localparam logic [31:0] BASE_B = 32'h1001_0000;
    localparam longint unsigned SPAN_BYTES = 4096;

    logic        clk;
    logic        reset;
    logic        mem_write;
    logic        forward_mm;
    logic [31:0] alu_out_m;
    logic [31:0] write_data_m;
    logic [31:0] result_w;
    logic [31:0] rd;
    logic [31:0] store_data;
    logic [31:0] rd_b;
    logic [31:0] store_data_b;

    int n_tests;
    int n_fail;

    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];

    data_memory_mux #(
        .DATA_W       (32),
        .DEPTH        (1024),
        .BASE_ADDR    (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_write    (mem_write),
        .forward_mm   (forward_mm),
        .alu_out_m    (alu_out_m),
        .write_data_m (write_data_m),
        .result_w     (result_w),
        .rd           (rd),
        .store_data   (store_data)
    );

    data_memory_mux #(
        .DATA_W       (32),
        .DEPTH        (1024),
        .BASE_ADDR    (BASE_B)
    ) dut_b (
        .clk          (clk),
        .reset        (reset),
        .mem_write    (mem_write),
        .forward_mm   (forward_mm),
        .alu_out_m    (alu_out_m),
        .write_data_m (write_data_m),
        .result_w     (result_w),
        .rd           (rd_b),
        .store_data   (store_data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain byte-address arithmetic over a word array.
    function automatic logic [31:0] ref_read(input logic [31:0] addr, input logic [31:0] base,
                                             input bit use_b);
        longint unsigned a;
        longint unsigned b;
        a = addr;
        b = base;
        if (a >= b && (a - b) < SPAN_BYTES)
            return use_b ? mem_b[(a - b) / 4] : mem_a[(a - b) / 4];
        return 32'h0;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [31:0] data);
        longint unsigned a;
        a = addr;
        if (a < SPAN_BYTES) mem_a[a / 4] = data;
        if (a >= longint'(BASE_B) && (a - longint'(BASE_B)) < SPAN_BYTES)
            mem_b[(a - longint'(BASE_B)) / 4] = data;
    endfunction

    // One store through the normal path; the model follows at the edge.
    task automatic store(input logic [31:0] addr, input logic [31:0] wd,
                         input logic fwd, input logic [31:0] res);
        @(negedge clk);
        alu_out_m    = addr;
        write_data_m = wd;
        result_w     = res;
        forward_mm   = fwd;
        mem_write    = 1'b1;
        @(posedge clk);
        model_write(addr, fwd ? res : wd);
        #1;
        mem_write = 1'b0;
    endtask

    task automatic read_at(input logic [31:0] addr);
        @(negedge clk);
        alu_out_m = addr;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] addrs [3];
        addrs[0] = 32'h0;
        addrs[1] = 32'h4;
        addrs[2] = 32'hFFC;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            read_at(addrs[i]);
            n_tests++;
            if (rd !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_read addr=%h rd=%h expected=%h", addrs[i], rd, 32'h0);
            end
        end
    endtask

    task automatic test_store_load();
        store(32'h8, 32'hDEAD_BEEF, 1'b0, 32'h0);
        read_at(32'h8);
        n_tests++;
        if (rd !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL load_0x8 rd=%h expected=%h", rd, 32'hDEAD_BEEF);
        end
        read_at(32'hA);
        n_tests++;
        if (rd !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL load_misaligned_0xA rd=%h expected=%h", rd, 32'hDEAD_BEEF);
        end
        read_at(32'hC);
        n_tests++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL load_0xC rd=%h expected=%h", rd, 32'h0);
        end
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        alu_out_m    = 32'h10;
        write_data_m = 32'hFFFF_FFFF;
        result_w     = 32'h1234_5678;
        forward_mm   = 1'b1;
        mem_write    = 1'b1;
        #1;
        n_tests++;
        if (store_data !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL fwd_store_data store_data=%h expected=%h", store_data, 32'h1234_5678);
        end
        @(posedge clk);
        model_write(32'h10, 32'h1234_5678);
        #1;
        mem_write  = 1'b0;
        forward_mm = 1'b0;
        #1;
        n_tests++;
        if (store_data !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL nofwd_store_data store_data=%h expected=%h", store_data, 32'hFFFF_FFFF);
        end
        read_at(32'h10);
        n_tests++;
        if (rd !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL fwd_load rd=%h expected=%h", rd, 32'h1234_5678);
        end
    endtask

    task automatic test_read_during_write();
        store(32'h20, 32'h1, 1'b0, 32'h0);
        @(negedge clk);
        alu_out_m    = 32'h20;
        write_data_m = 32'h2;
        forward_mm   = 1'b0;
        mem_write    = 1'b1;
        #1;
        n_tests++;
        if (rd !== 32'h1) begin
            n_fail++;
            $display("FAIL rdw_before_edge rd=%h expected=%h", rd, 32'h1);
        end
        @(posedge clk);
        model_write(32'h20, 32'h2);
        #1;
        n_tests++;
        if (rd !== 32'h2) begin
            n_fail++;
            $display("FAIL rdw_after_edge rd=%h expected=%h", rd, 32'h2);
        end
        mem_write = 1'b0;
    endtask

    task automatic test_out_of_range();
        store(32'h0, 32'h1111_1111, 1'b0, 32'h0);
        store(32'h1000, 32'hAAAA_5555, 1'b0, 32'h0);
        read_at(32'h1000);
        n_tests++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL oor_read_0x1000 rd=%h expected=%h", rd, 32'h0);
        end
        read_at(32'h0);
        n_tests++;
        if (rd !== 32'h1111_1111) begin
            n_fail++;
            $display("FAIL oor_alias_0x0 rd=%h expected=%h", rd, 32'h1111_1111);
        end
        read_at(32'hFFC);
        n_tests++;
        if (rd !== ref_read(32'hFFC, 32'h0, 1'b0)) begin
            n_fail++;
            $display("FAIL top_word_0xFFC rd=%h expected=%h", rd, ref_read(32'hFFC, 32'h0, 1'b0));
        end
        // Second instance with a non-zero base window.
        store(32'h1001_0004, 32'hCAFE_F00D, 1'b0, 32'h0);
        read_at(32'h1000_FFFC);
        n_tests++;
        if (rd_b !== 32'h0) begin
            n_fail++;
            $display("FAIL base_below_window rd=%h expected=%h", rd_b, 32'h0);
        end
        read_at(32'h1001_0004);
        n_tests++;
        if (rd_b !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL base_in_window rd=%h expected=%h", rd_b, 32'hCAFE_F00D);
        end
        n_tests++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL base0_high_addr rd=%h expected=%h", rd, 32'h0);
        end
        read_at(32'h1001_1000);
        n_tests++;
        if (rd_b !== 32'h0) begin
            n_fail++;
            $display("FAIL base_above_window rd=%h expected=%h", rd_b, 32'h0);
        end
    endtask

    task automatic test_async_reset();
        store(32'h0, 32'h5555_AAAA, 1'b0, 32'h0);
        store(32'h4, 32'h0BAD_F00D, 1'b0, 32'h0);
        read_at(32'h4);
        n_tests++;
        if (rd !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL prefill_0x4 rd=%h expected=%h", rd, 32'h0BAD_F00D);
        end
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        n_tests++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL async_clear_0x4 rd=%h expected=%h", rd, 32'h0);
        end
        // Store attempted while reset is held must be lost.
        alu_out_m    = 32'h0;
        write_data_m = 32'h7777_7777;
        mem_write    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_write = 1'b0;
        reset     = 1'b0;
        #1;
        n_tests++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL write_during_reset rd=%h expected=%h", rd, 32'h0);
        end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] res;
        logic        we;
        logic        fwd;
        for (int i = 0; i < 300; i++) begin
            addr = 32'($urandom_range(0, 32'h13FF));
            if ((i % 7) == 0) addr = BASE_B + 32'($urandom_range(0, 32'h103F)) - 32'h20;
            wd  = $urandom;
            res = $urandom;
            we  = 1'($urandom_range(0, 1));
            fwd = 1'($urandom_range(0, 1));
            @(negedge clk);
            alu_out_m    = addr;
            write_data_m = wd;
            result_w     = res;
            forward_mm   = fwd;
            mem_write    = we;
            #1;
            n_tests++;
            if (store_data !== (fwd ? res : wd)) begin
                n_fail++;
                $display("FAIL rand_store_data it=%0d got=%h expected=%h", i, store_data, fwd ? res : wd);
            end
            n_tests++;
            if (rd !== ref_read(addr, 32'h0, 1'b0) || rd_b !== ref_read(addr, BASE_B, 1'b1)) begin
                n_fail++;
                $display("FAIL rand_load it=%0d addr=%h rd=%h/%h expected=%h/%h", i, addr, rd, rd_b,
                         ref_read(addr, 32'h0, 1'b0), ref_read(addr, BASE_B, 1'b1));
            end
            @(posedge clk);
            if (we) model_write(addr, fwd ? res : wd);
        end
        mem_write = 1'b0;
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        reset        = 1'b0;
        mem_write    = 1'b0;
        forward_mm   = 1'b0;
        alu_out_m    = 32'h0;
        write_data_m = 32'h0;
        result_w     = 32'h0;
        model_clear();
        #1;
        reset = 1'b1;
        #1;
        n_tests++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL power_on_reset rd=%h expected=%h", rd, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;

        test_reset();
        test_store_load();
        test_forwarding();
        test_read_during_write();
        test_out_of_range();
        test_async_reset();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_data_memory_mux
